// File: rtl/mem_dump_reader_pkg.sv
// Shared definitions for the memory dump reader: FSM encoding and stream constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_dump_reader_pkg;

  // Dump sequencer states
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT     = 3'd1,
    S_SEND_HI  = 3'd2,
    S_SEND_LO  = 3'd3,
    S_SEND_SUM = 3'd4,
    S_FIN      = 3'd5
  } state_e;

  // Each memory word leaves as this many bytes, high byte first
  localparam int BYTES_PER_WORD = 2;

  // Width of the running modular checksum
  localparam int CSUM_W = 8;

  // Modular add of one data byte into the running checksum
  function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] acc,
                                                 input logic [7:0]        data_byte);
    return acc + data_byte;
  endfunction

endpackage

// File: rtl/mem_dump_reader.sv
// Walks FIRST_ADDR..LAST_ADDR on the memory test port and streams each word as hi/lo bytes, then one checksum byte.
// Latency: each word spends RD_LAT+1 cycles in WAIT (address settle plus countdown) before its high byte is offered.
// Backpressure: tx_valid/tx_ready handshake; tx_data and all internal state are held while tx_ready is low.
module mem_dump_reader #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 16,
  parameter int FIRST_ADDR = 0,
  parameter int LAST_ADDR  = 63,
  parameter int RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] addr_test,
  input  logic [DATA_W-1:0] rd_test,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);
  import mem_dump_reader_pkg::*;

  localparam int BYTE_W = DATA_W / BYTES_PER_WORD;
  localparam int CNT_W  = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(RD_LAT);
  localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(FIRST_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(LAST_ADDR);

  // Registered state
  state_e              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [CNT_W-1:0]    r_cnt;
  logic [BYTE_W-1:0]   r_word_lo;
  logic [BYTE_W-1:0]   r_tx_data;
  logic                r_tx_valid;
  logic                r_busy;
  logic                r_done;
  logic [CSUM_W-1:0]   r_csum;

  // Next-state values
  state_e              w_state;
  logic [ADDR_W-1:0]   w_addr;
  logic [CNT_W-1:0]    w_cnt;
  logic [BYTE_W-1:0]   w_word_lo;
  logic [BYTE_W-1:0]   w_tx_data;
  logic                w_tx_valid;
  logic                w_busy;
  logic                w_done;
  logic [CSUM_W-1:0]   w_csum;

  logic                w_accept;
  logic [CSUM_W-1:0]   w_csum_acc;

  // A byte leaves only when it is actually offered; tx_ready alone does nothing
  assign w_accept   = r_tx_valid & tx_ready;
  // Checksum including the byte currently on tx_data
  assign w_csum_acc = csum_add(r_csum, r_tx_data);

  // Next-state and output decode for the dump sequencer
  always_comb begin
    w_state    = r_state;
    w_addr     = r_addr;
    w_cnt      = r_cnt;
    w_word_lo  = r_word_lo;
    w_tx_data  = r_tx_data;
    w_tx_valid = r_tx_valid;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_csum     = r_csum;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_addr  = ADDR_FIRST;
          w_csum  = '0;
          w_cnt   = CNT_RELOAD;
          w_busy  = 1'b1;
          w_state = S_WAIT;
        end
      end

      S_WAIT: begin
        if (r_cnt == '0) begin
          // Low byte is kept for the next beat; high byte goes straight out
          w_word_lo  = rd_test[BYTE_W-1:0];
          w_tx_data  = rd_test[DATA_W-1 -: BYTE_W];
          w_tx_valid = 1'b1;
          w_state    = S_SEND_HI;
        end else begin
          w_cnt = r_cnt - CNT_W'(1);
        end
      end

      S_SEND_HI: begin
        if (w_accept) begin
          w_csum    = w_csum_acc;
          w_tx_data = r_word_lo;
          w_state   = S_SEND_LO;
        end
      end

      S_SEND_LO: begin
        if (w_accept) begin
          w_csum = w_csum_acc;
          // Compare before incrementing so a window ending at the top address never wraps
          if (r_addr == ADDR_LAST) begin
            w_tx_data = w_csum_acc;
            w_state   = S_SEND_SUM;
          end else begin
            w_addr     = r_addr + ADDR_W'(1);
            w_tx_valid = 1'b0;
            w_cnt      = CNT_RELOAD;
            w_state    = S_WAIT;
          end
        end
      end

      S_SEND_SUM: begin
        if (w_accept) begin
          w_tx_valid = 1'b0;
          w_busy     = 1'b0;
          w_done     = 1'b1;
          w_state    = S_FIN;
        end
      end

      S_FIN: begin
        // start is deliberately not looked at here
        w_state = S_IDLE;
      end

      default: begin
        w_state    = S_IDLE;
        w_tx_valid = 1'b0;
        w_busy     = 1'b0;
      end
    endcase
  end

  // State register with synchronous active-low reset; reset abandons any dump in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_addr     <= ADDR_FIRST;
      r_cnt      <= '0;
      r_word_lo  <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_csum     <= '0;
    end else begin
      r_state    <= w_state;
      r_addr     <= w_addr;
      r_cnt      <= w_cnt;
      r_word_lo  <= w_word_lo;
      r_tx_data  <= w_tx_data;
      r_tx_valid <= w_tx_valid;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_csum     <= w_csum;
    end
  end

  assign addr_test = r_addr;
  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Scoreboard bench for mem_dump_reader: full-window dumps, one-word window, read-latency variants.
// Expected bytes are queued when a dump is started; negedge monitors pop and compare on each accepted byte.
// tx_ready is driven randomly or tied high; reset and a stray start are injected mid-dump.
module tb_mem_dump_reader;

  typedef struct packed {
    logic [7:0] b;
    logic [5:0] a;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        tx_ready;
  logic [5:0]  addr;
  logic [15:0] rd;
  logic [7:0]  txd;
  logic        txv;
  logic        busy;
  logic        done;

  logic [15:0] mem  [64];
  logic [15:0] amem [64];

  // Auxiliary instances: 0 = RD_LAT 0 window 0..3, 1 = one-word window at 5, 2 = RD_LAT 2 window 0..3
  logic        start_a;
  logic        ready_a;
  logic [5:0]  aaddr0, aaddr1, aaddr2;
  logic [15:0] rd_a0, rd_a1, rd_a2, rd_a2_p;
  logic [7:0]  atxd0, atxd1, atxd2;
  logic        atxv0, atxv1, atxv2;
  logic        abusy0, abusy1, abusy2;
  logic        adone0, adone1, adone2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t       q [$];
  logic [7:0] aq0 [$];
  logic [7:0] aq1 [$];
  logic [7:0] aq2 [$];

  int sent_cnt = 0;
  int done_seen = 0;
  int dones_exp = 0;
  bit prev_stall = 0;
  logic [7:0] prev_d = '0;
  bit chk_done_next = 0;

  int acnt [3];
  int at0 [3];
  int at2 [3];
  int adn [3];
  bit apend [3];

  mem_dump_reader #(.ADDR_W(6), .DATA_W(16), .FIRST_ADDR(0), .LAST_ADDR(63), .RD_LAT(1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .addr_test(addr), .rd_test(rd),
    .tx_data(txd), .tx_valid(txv), .tx_ready(tx_ready), .busy(busy), .done(done));

  mem_dump_reader #(.ADDR_W(6), .DATA_W(16), .FIRST_ADDR(0), .LAST_ADDR(3), .RD_LAT(0)) u_lat0 (
    .clk(clk), .reset(reset), .start(start_a), .addr_test(aaddr0), .rd_test(rd_a0),
    .tx_data(atxd0), .tx_valid(atxv0), .tx_ready(ready_a), .busy(abusy0), .done(adone0));

  mem_dump_reader #(.ADDR_W(6), .DATA_W(16), .FIRST_ADDR(5), .LAST_ADDR(5), .RD_LAT(1)) u_one (
    .clk(clk), .reset(reset), .start(start_a), .addr_test(aaddr1), .rd_test(rd_a1),
    .tx_data(atxd1), .tx_valid(atxv1), .tx_ready(ready_a), .busy(abusy1), .done(adone1));

  mem_dump_reader #(.ADDR_W(6), .DATA_W(16), .FIRST_ADDR(0), .LAST_ADDR(3), .RD_LAT(2)) u_lat2 (
    .clk(clk), .reset(reset), .start(start_a), .addr_test(aaddr2), .rd_test(rd_a2),
    .tx_data(atxd2), .tx_valid(atxv2), .tx_ready(ready_a), .busy(abusy2), .done(adone2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory models with the read latency each instance is configured for
  always @(posedge clk) rd <= mem[addr];
  assign rd_a0 = amem[aaddr0];
  always @(posedge clk) rd_a1 <= amem[aaddr1];
  always @(posedge clk) begin
    rd_a2_p <= amem[aaddr2];
    rd_a2   <= rd_a2_p;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask

  // Reference: every word of the window as hi then lo byte, then the mod-256 sum of all of them
  task automatic push_main();
    logic [7:0] s;
    s = '0;
    for (int a = 0; a < 64; a++) begin
      q.push_back({mem[a][15:8], 6'(a)});
      q.push_back({mem[a][7:0], 6'(a)});
      s = s + mem[a][15:8] + mem[a][7:0];
    end
    q.push_back({s, 6'd63});
  endtask

  // Main monitor: byte/address scoreboard, hold-while-stalled, done timing
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (prev_stall) begin
        chk("hold_valid", {31'd0, txv}, 32'd1);
        chk("hold_data", {24'd0, txd}, {24'd0, prev_d});
      end
      prev_stall = txv && !tx_ready;
      prev_d     = txd;
      if (chk_done_next) begin
        chk("done_after_sum", {31'd0, done}, 32'd1);
        chk("busy_after_sum", {31'd0, busy}, 32'd0);
        chk_done_next = 0;
      end
      if (done) done_seen++;
      if (txv) chk("busy_while_valid", {31'd0, busy}, 32'd1);
      if (txv && tx_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_byte got %02h want none", txd);
        end else begin
          e = q.pop_front();
          checks++;
          if (txd !== e.b || addr !== e.a) begin
            errors++;
            $display("FAIL byte%0d got %02h@%0d want %02h@%0d", sent_cnt, txd, addr, e.b, e.a);
          end
          if (q.size() == 0) chk_done_next = 1;
        end
        sent_cnt++;
      end
    end else begin
      prev_stall    = 0;
      chk_done_next = 0;
    end
  end

  task automatic aux_mon(input int k, input logic v, input logic [7:0] d, input logic dn);
    int sz;
    logic [7:0] e;
    if (apend[k]) begin
      chk($sformatf("aux%0d_done", k), {31'd0, dn}, 32'd1);
      apend[k] = 0;
    end
    if (dn) adn[k]++;
    if (v) begin
      case (k)
        0:       sz = aq0.size();
        1:       sz = aq1.size();
        default: sz = aq2.size();
      endcase
      if (sz == 0) begin
        checks++;
        errors++;
        $display("FAIL aux%0d_extra got %02h want none", k, d);
      end else begin
        case (k)
          0:       e = aq0.pop_front();
          1:       e = aq1.pop_front();
          default: e = aq2.pop_front();
        endcase
        chk($sformatf("aux%0d_byte%0d", k, acnt[k]), {24'd0, d}, {24'd0, e});
        if (acnt[k] == 0) at0[k] = cyc;
        if (acnt[k] == 2) at2[k] = cyc;
        acnt[k]++;
        if (sz == 1) apend[k] = 1;
      end
    end
  endtask

  // Auxiliary monitors (tx_ready tied high, so every valid byte is accepted)
  always @(negedge clk) begin
    if (reset) begin
      aux_mon(0, atxv0, atxd0, adone0);
      aux_mon(1, atxv1, atxd1, adone1);
      aux_mon(2, atxv2, atxd2, adone2);
    end
  end

  task automatic run_main(input bit rnd, input bit mid);
    int d0;
    int c;
    bit fired;
    d0 = done_seen;
    fired = 0;
    sent_cnt = 0;
    push_main();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 0;
    while (done_seen == d0 && c < 3000) begin
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = mid && !fired && busy && (addr == 6'd10);
      if (start) fired = 1;
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;
    chk("dump_in_budget", {31'd0, c < 3000}, 32'd1);
    chk("queue_drained", q.size(), 32'd0);
    if (mid) chk("mid_start_issued", {31'd0, fired}, 32'd1);
    q.delete();
    dones_exp++;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_after_dump", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int c;
    int d0;
    logic [7:0] s;
    reset = 1'b0;
    start = 1'b0;
    tx_ready = 1'b0;
    start_a = 1'b0;
    ready_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      acnt[k] = 0; at0[k] = 0; at2[k] = 0; adn[k] = 0; apend[k] = 0;
    end
    for (int i = 0; i < 64; i++) begin
      mem[i]  = 16'hA000 + 16'(i);
      amem[i] = 16'($urandom);
    end
    amem[5] = 16'h1234;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", {26'd0, addr}, 32'd0);
    chk("rst_txd", {24'd0, txd}, 32'd0);
    chk("rst_txv", {31'd0, txv}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_addr_one", {26'd0, aaddr1}, 32'd5);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // One-word window and read-latency variants
    aq1.push_back(8'h12); aq1.push_back(8'h34); aq1.push_back(8'h46);
    s = '0;
    for (int a = 0; a < 4; a++) begin
      aq0.push_back(amem[a][15:8]); aq0.push_back(amem[a][7:0]);
      aq2.push_back(amem[a][15:8]); aq2.push_back(amem[a][7:0]);
      s = s + amem[a][15:8] + amem[a][7:0];
    end
    aq0.push_back(s);
    aq2.push_back(s);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    c = 0;
    while ((adn[0] == 0 || adn[1] == 0 || adn[2] == 0) && c < 300) begin
      @(posedge clk); #1;
      c++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("aux_in_budget", {31'd0, c < 300}, 32'd1);
    chk("aux0_drained", aq0.size(), 32'd0);
    chk("aux1_drained", aq1.size(), 32'd0);
    chk("aux2_drained", aq2.size(), 32'd0);
    chk("aux1_single_done", adn[1], 32'd1);
    // Two extra read-latency cycles add exactly two cycles to each word
    chk("lat_period_delta", (at2[2] - at0[2]) - (at2[0] - at0[0]), 32'd2);

    // Full window, ready tied high, then with random backpressure
    run_main(0, 0);
    run_main(1, 0);
    // Fresh random contents, stray start while busy at address 10
    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
    run_main(1, 1);

    // Reset while the low byte of address 20 is pending
    sent_cnt = 0;
    push_main();
    @(posedge clk); #1;
    start = 1'b1;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 0;
    while (sent_cnt != 41 && c < 500) begin
      @(posedge clk); #1;
      c++;
    end
    chk("reach_addr20", {31'd0, c < 500}, 32'd1);
    chk("abort_addr", {26'd0, addr}, 32'd20);
    chk("abort_valid_before", {31'd0, txv}, 32'd1);
    tx_ready = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_txv", {31'd0, txv}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_addr_first", {26'd0, addr}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    reset = 1'b1;
    q.delete();
    d0 = done_seen;
    repeat (5) @(posedge clk);
    #1;
    chk("no_done_after_abort", done_seen - d0, 32'd0);
    chk("idle_after_abort", {31'd0, busy}, 32'd0);

    // Restart after abort: from FIRST_ADDR with checksum from zero
    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
    run_main(1, 0);

    chk("done_count", done_seen, dones_exp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
